// File: rtl/axi4_slave_pkg.sv
// Shared types for the AXI4 slave read-address generator.
// Holds burst encodings, the AR command record, FSM states and the 4KB page size.
package axi4_slave_pkg;

  localparam int BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_gen_state_t;

  // Default-width AR command; parametrised users pass their own struct type.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [2:0]  size;
    burst_t      burst;
  } ar_cmd_t;

endpackage

// File: rtl/axi4_slave_cmd_fifo.sv
// Generic synchronous FIFO for AR commands.
// DEPTH must be a power of two so the pointers wrap naturally.
module axi4_slave_cmd_fifo
  import axi4_slave_pkg::*;
#(
  parameter type T     = ar_cmd_t,
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  T                 mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == {(PTR_W+1){1'b0}});
  assign count     = count_r;
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + (PTR_W+1)'(1);
      end else if (!do_push_s && do_pop_s) begin
        count_r <= count_r - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/axi4_slave_read_addr_gen.sv
// AXI4 slave read-address generator: queues AR commands and expands each
// burst (FIXED / INCR / WRAP, reserved treated as INCR) into per-beat addresses.
// Optional protocol checking is enabled by AXI4_SLAVE_AR_PROTOCOL_CHK_EN;
// without it beat_err is tied low.
module axi4_slave_read_addr_gen
  import axi4_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [LEN_WIDTH-1:0]  arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic                  beat_last,
  output logic                  beat_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    burst_t                burst;
  } cmd_t;

  cmd_t                  push_cmd_s;
  cmd_t                  head_s;
  logic                  push_s;
  logic                  full_s;
  logic                  empty_s;
  logic [CNT_W-1:0]      count_s;
  logic                  handshake_s;
  logic                  load_s;
  logic                  ld_err_s;

  rd_gen_state_t         state_r;
  logic [ADDR_WIDTH-1:0] cur_addr_r;
  logic [ADDR_WIDTH-1:0] start_addr_r;
  logic [ID_WIDTH-1:0]   id_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [2:0]            size_r;
  burst_t                burst_r;
  logic [LEN_WIDTH-1:0]  beat_cnt_r;
  logic                  last_r;
  logic                  err_r;

  logic [ADDR_WIDTH-1:0] sz_s;
  logic [ADDR_WIDTH-1:0] wrap_bytes_s;
  logic [ADDR_WIDTH-1:0] wrap_lo_s;
  logic [ADDR_WIDTH-1:0] step_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;

  // arready must read low while reset is held, hence the direct rst term.
  assign arready     = !full_s && !rst;
  assign push_s      = arvalid && arready;
  assign handshake_s = (state_r == BURST) && beat_ready;
  assign load_s      = !empty_s && ((state_r == IDLE) || (handshake_s && last_r));

  // Pack the AR channel into a command record.
  always_comb begin
    push_cmd_s.addr  = araddr;
    push_cmd_s.id    = arid;
    push_cmd_s.len   = arlen;
    push_cmd_s.size  = arsize;
    push_cmd_s.burst = burst_t'(arburst);
  end

  axi4_slave_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_cmd_s),
    .pop       (load_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Next beat address from the active burst's parameters.
  always_comb begin
    sz_s         = ADDR_WIDTH'(1) << size_r;
    wrap_bytes_s = (ADDR_WIDTH'(len_r) + ADDR_WIDTH'(1)) << size_r;
    wrap_lo_s    = start_addr_r & ~(wrap_bytes_s - ADDR_WIDTH'(1));
    step_s       = cur_addr_r + sz_s;
    next_addr_s  = cur_addr_r;
    case (burst_r)
      FIXED: begin
        next_addr_s = cur_addr_r;
      end
      WRAP: begin
        if (step_s == (wrap_lo_s + wrap_bytes_s)) begin
          next_addr_s = wrap_lo_s;
        end else begin
          next_addr_s = step_s;
        end
      end
      default: begin
        // INCR and reserved: align down, then step one beat.
        next_addr_s = (cur_addr_r & ~(sz_s - ADDR_WIDTH'(1))) + sz_s;
      end
    endcase
  end

`ifdef AXI4_SLAVE_AR_PROTOCOL_CHK_EN
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BYTES));

  logic [ADDR_WIDTH-1:0] ld_sz_s;
  logic [31:0]           ld_bytes_s;
  logic [31:0]           ld_end_s;
  logic                  ld_wrap_len_ok_s;

  // Legality of the command at the FIFO head, sampled when it is loaded.
  always_comb begin
    ld_sz_s          = ADDR_WIDTH'(1) << head_s.size;
    ld_bytes_s       = (32'(head_s.len) + 32'd1) << head_s.size;
    ld_end_s         = 32'(head_s.addr[11:0]) + ld_bytes_s;
    ld_wrap_len_ok_s = (head_s.len == LEN_WIDTH'(1)) || (head_s.len == LEN_WIDTH'(3)) ||
                       (head_s.len == LEN_WIDTH'(7)) || (head_s.len == LEN_WIDTH'(15));
    ld_err_s = (head_s.burst == RSVD) ||
               (head_s.size > MAX_SIZE) ||
               ((head_s.burst == WRAP) && !ld_wrap_len_ok_s) ||
               ((head_s.burst == WRAP) &&
                ((head_s.addr & (ld_sz_s - ADDR_WIDTH'(1))) != {ADDR_WIDTH{1'b0}})) ||
               ((head_s.burst == INCR) && (ld_end_s > 32'(BOUNDARY_4K)));
  end
`else
  assign ld_err_s = 1'b0;
`endif

  // Burst FSM and registered beat state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cur_addr_r   <= {ADDR_WIDTH{1'b0}};
      start_addr_r <= {ADDR_WIDTH{1'b0}};
      id_r         <= {ID_WIDTH{1'b0}};
      len_r        <= {LEN_WIDTH{1'b0}};
      size_r       <= 3'd0;
      burst_r      <= FIXED;
      beat_cnt_r   <= {LEN_WIDTH{1'b0}};
      last_r       <= 1'b0;
      err_r        <= 1'b0;
    end else if (load_s) begin
      state_r      <= BURST;
      cur_addr_r   <= head_s.addr;
      start_addr_r <= head_s.addr;
      id_r         <= head_s.id;
      len_r        <= head_s.len;
      size_r       <= head_s.size;
      burst_r      <= head_s.burst;
      beat_cnt_r   <= {LEN_WIDTH{1'b0}};
      last_r       <= (head_s.len == {LEN_WIDTH{1'b0}});
      err_r        <= ld_err_s;
    end else if (handshake_s && last_r) begin
      state_r      <= IDLE;
    end else if (handshake_s) begin
      beat_cnt_r   <= beat_cnt_r + LEN_WIDTH'(1);
      cur_addr_r   <= next_addr_s;
      last_r       <= ((beat_cnt_r + LEN_WIDTH'(1)) == len_r);
    end
  end

  assign beat_valid = (state_r == BURST);
  assign beat_addr  = cur_addr_r;
  assign beat_id    = id_r;
  assign beat_last  = last_r;
  assign beat_err   = err_r;
  assign busy       = (count_s != {CNT_W{1'b0}}) || (state_r == BURST);

endmodule

// File: tb/tb_axi4_slave_read_addr_gen.sv
// Directed bench for axi4_slave_read_addr_gen with a beat scoreboard.
// Honours AXI4_SLAVE_AR_PROTOCOL_CHK_EN when computing expected beat_err.
module tb_axi4_slave_read_addr_gen;

`ifdef AXI4_SLAVE_AR_PROTOCOL_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = 32'd0;
  logic [3:0]  arid = 4'd0;
  logic [7:0]  arlen = 8'd0;
  logic [2:0]  arsize = 3'd0;
  logic [1:0]  arburst = 2'd0;
  logic        beat_valid;
  logic        beat_ready = 1'b1;
  logic [31:0] beat_addr;
  logic [3:0]  beat_id;
  logic        beat_last;
  logic        beat_err;
  logic        busy;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic        last;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  logic        stall_p = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [3:0]  prev_id = 4'd0;
  logic        prev_last = 1'b0;
  logic        prev_err = 1'b0;

  axi4_slave_read_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .arid       (arid),
    .arlen      (arlen),
    .arsize     (arsize),
    .arburst    (arburst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_id    (beat_id),
    .beat_last  (beat_last),
    .beat_err   (beat_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference expansion of one burst into expected beats.
  task automatic push_exp(input logic [31:0] a, input logic [3:0] id, input int len,
                          input int size, input logic [1:0] burst, input logic err);
    logic [31:0] cur, sz, wb, lo;
    beat_t b;
    cur = a;
    sz  = 32'd1 << size;
    wb  = sz * (len + 1);
    lo  = a & ~(wb - 32'd1);
    for (int i = 0; i <= len; i++) begin
      b.addr = cur;
      b.id   = id;
      b.last = (i == len);
      b.err  = CHK_EN ? err : 1'b0;
      exp_q.push_back(b);
      if (burst == 2'b00) begin
        cur = cur;
      end else if (burst == 2'b10) begin
        cur = cur + sz;
        if (cur == lo + wb) cur = lo;
      end else begin
        cur = (cur & ~(sz - 32'd1)) + sz;
      end
    end
  endtask

  // Issue one AR; returns just after the handshake edge.
  task automatic ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input logic err);
    int n;
    araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    push_exp(a, id, int'(len), int'(size), burst, err);
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      stall_p <= 1'b0;
    end else begin
      if (stall_p) begin
        chk("stall_valid", beat_valid, 1'b1);
        chk("stall_addr", beat_addr, prev_addr);
        chk("stall_id", beat_id, prev_id);
        chk("stall_last", beat_last, prev_last);
        chk("stall_err", beat_err, prev_err);
      end
      if (beat_valid && beat_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_addr", beat_addr, e.addr);
          chk("beat_id", beat_id, e.id);
          chk("beat_last", beat_last, e.last);
          chk("beat_err", beat_err, e.err);
        end
      end
      stall_p   <= beat_valid && !beat_ready;
      prev_addr <= beat_addr;
      prev_id   <= beat_id;
      prev_last <= beat_last;
      prev_err  <= beat_err;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    int n, gap;

    // Reset state.
    @(negedge clk);
    chk("rst_arready", arready, 1'b0);
    chk("rst_valid", beat_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", beat_addr, 32'd0);
    chk("rst_id", beat_id, 4'd0);
    chk("rst_last", beat_last, 1'b0);
    chk("rst_err", beat_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel_arready", arready, 1'b1);
    @(posedge clk); #1;

    // INCR unaligned start with first-beat latency.
    ar(32'h1002, 4'd1, 8'd3, 3'd2, 2'b01, 1'b0);
    @(negedge clk);
    chk("lat_e_plus0", beat_valid, 1'b0);
    @(negedge clk);
    chk("lat_e_plus1", beat_valid, 1'b1);
    wait_idle();

    // WRAP crossing the wrap boundary.
    @(posedge clk); #1;
    ar(32'h0038, 4'd2, 8'd3, 3'd2, 2'b10, 1'b0);
    wait_idle();

    // FIXED with beat_ready pattern 1,0,0,1.
    @(posedge clk); #1;
    beat_ready = 1'b0;
    ar(32'h0200, 4'd5, 8'd2, 3'd2, 2'b00, 1'b0);
    n = 0;
    while (!beat_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fixed_valid", beat_valid, 1'b1);
    pat = 4'b1001;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      beat_ready = pat[3-i];
      @(posedge clk); #1;
    end
    beat_ready = 1'b1;
    wait_idle();

    // Backpressure: five ARs fill the FIFO behind the active burst.
    @(posedge clk); #1;
    beat_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ar(32'h0100 * (i + 1), 4'(i + 3), 8'd1, 3'd2, 2'b01, 1'b0);
    end
    @(negedge clk);
    chk("bp_full", arready, 1'b0);
    @(posedge clk); #1;
    beat_ready = 1'b1;
    @(negedge clk);
    chk("bp_still_full0", arready, 1'b0);
    @(negedge clk);
    chk("bp_still_full1", arready, 1'b0);
    @(negedge clk);
    chk("bp_ready_after_pop", arready, 1'b1);
    n = 0;
    gap = 0;
    while (busy && n < 100) begin
      if (!beat_valid) gap++;
      @(negedge clk);
      n++;
    end
    chk("bp_no_gap", gap, 0);
    chk("bp_idle", busy, 1'b0);

    // Reset during the second beat of an eight-beat burst.
    @(posedge clk); #1;
    ar(32'h0400, 4'd9, 8'd7, 3'd2, 2'b01, 1'b0);
    n = 0;
    while (!beat_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", beat_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_arready", arready, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rel_arready", arready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_beat", beat_valid, 1'b0);
    end

    // Protocol-check cases: 4KB crossing, legal WRAP, reserved burst.
    @(posedge clk); #1;
    ar(32'h0FF0, 4'd10, 8'd7, 3'd2, 2'b01, 1'b1);
    wait_idle();
    @(posedge clk); #1;
    ar(32'h0040, 4'd11, 8'd3, 3'd2, 2'b10, 1'b0);
    wait_idle();
    @(posedge clk); #1;
    ar(32'h0501, 4'd12, 8'd2, 3'd1, 2'b11, 1'b1);
    wait_idle();
    @(posedge clk); #1;
    ar(32'h0600, 4'd13, 8'd0, 3'd2, 2'b01, 1'b0);
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
